// File: rtl/ret_fsm_if.sv
// Bus bundle between the return sequencer and decode/stack/PC logic.
interface ret_fsm_if;
    logic        ret;
    logic        rti;
    logic [15:0] mem_data;
    logic [15:0] out;
    logic        stall;
    logic [31:0] pc_out;
    logic        pc_load;
    logic [3:0]  flags_out;
    logic        flags_load;

    modport master (
        output ret, rti, mem_data,
        input  out, stall, pc_out, pc_load, flags_out, flags_load
    );

    modport slave (
        input  ret, rti, mem_data,
        output out, stall, pc_out, pc_load, flags_out, flags_load
    );
endinterface

// File: rtl/ret_fsm.sv
// Return sequencer: pops PC (high, low) and, with RET_FSM_RTI_EN, flags,
// then strobes the assembled return address into the PC.
module ret_fsm (
    input  logic     clk,
    input  logic     reset,
    ret_fsm_if.slave bus
);
    localparam logic [15:0] UOP_NOP         = 16'd0;
    localparam logic [15:0] UOP_POP_PC_HIGH = 16'b101;
    localparam logic [15:0] UOP_POP_PC_LOW  = 16'b110;
    localparam logic [15:0] UOP_POP_FLAGS   = 16'b111;
    localparam logic [15:0] UOP_LOAD_PC     = 16'b1000;

    typedef enum logic [2:0] {
        IDLE,
        POP_H,
        POP_L,
        POP_F,
        LOAD
    } state_t;

    state_t      state;
    logic        kind_rti;
    logic        rti_in;
    logic [15:0] pc_high_q;
    logic [15:0] pc_low_q;
    logic [3:0]  flags_q;

`ifdef RET_FSM_RTI_EN
    assign rti_in = bus.rti;
`else
    assign rti_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            kind_rti       <= 1'b0;
            pc_high_q      <= '0;
            pc_low_q       <= '0;
            flags_q        <= '0;
            bus.out        <= UOP_NOP;
            bus.stall      <= 1'b0;
            bus.pc_out     <= '0;
            bus.pc_load    <= 1'b0;
            bus.flags_out  <= '0;
            bus.flags_load <= 1'b0;
        end else begin
            bus.pc_load    <= 1'b0;
            bus.flags_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ret | rti_in) begin
                        state     <= POP_H;
                        kind_rti  <= rti_in;
                        bus.out   <= UOP_POP_PC_HIGH;
                        bus.stall <= 1'b1;
                    end
                end
                POP_H: begin
                    state   <= POP_L;
                    bus.out <= UOP_POP_PC_LOW;
                end
                POP_L: begin
                    pc_high_q <= bus.mem_data;
                    if (kind_rti) begin
                        state   <= POP_F;
                        bus.out <= UOP_POP_FLAGS;
                    end else begin
                        state   <= LOAD;
                        bus.out <= UOP_LOAD_PC;
                    end
                end
                POP_F: begin
                    pc_low_q <= bus.mem_data;
                    state    <= LOAD;
                    bus.out  <= UOP_LOAD_PC;
                end
                LOAD: begin
                    state       <= IDLE;
                    bus.out     <= UOP_NOP;
                    bus.stall   <= 1'b0;
                    bus.pc_load <= 1'b1;
                    if (kind_rti) begin
                        bus.pc_out <= {pc_high_q, pc_low_q};
`ifdef RET_FSM_RTI_EN
                        flags_q        <= bus.mem_data[3:0];
                        bus.flags_out  <= bus.mem_data[3:0];
                        bus.flags_load <= 1'b1;
`endif
                    end else begin
                        // RET's low half arrives in LOAD itself; bypass it
                        pc_low_q   <= bus.mem_data;
                        bus.pc_out <= {pc_high_q, bus.mem_data};
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.out   <= UOP_NOP;
                    bus.stall <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ret_fsm.sv
// Scoreboard bench for ret_fsm: driver queues expected micro-ops and
// PC/flag loads, a negedge monitor pops and compares them.
module tb_ret_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [15:0] uop;
    } uop_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        fl;
        logic [3:0]  f;
    } pc_t;

    uop_t uq[$];
    pc_t  pq[$];

    ret_fsm_if bus ();

    ret_fsm dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.stall === 1'b1) begin
                if (uq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL uop_unexpected: got %0h expected none (cycle %0d)",
                             bus.out, cyc);
                end else begin
                    uop_t u;
                    u = uq.pop_front();
                    check("uop_cycle", cyc, u.cyc);
                    check("uop_code", {16'd0, bus.out}, {16'd0, u.uop});
                end
            end else begin
                check("idle_out", {16'd0, bus.out}, 32'd0);
            end
            if (bus.pc_load === 1'b1 || bus.flags_load === 1'b1) begin
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL load_unexpected: got pc_load=%0b flags_load=%0b expected none (cycle %0d)",
                             bus.pc_load, bus.flags_load, cyc);
                end else begin
                    pc_t p;
                    p = pq.pop_front();
                    check("load_cycle", cyc, p.cyc);
                    check("pc_load", {31'd0, bus.pc_load}, 32'd1);
                    check("pc_out", bus.pc_out, p.pc);
                    check("flags_load", {31'd0, bus.flags_load}, {31'd0, p.fl});
                    if (p.fl)
                        check("flags_out", {28'd0, bus.flags_out}, {28'd0, p.f});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ret(input logic [15:0] hi, input logic [15:0] lo,
                           input logic also_rti);
        int t0;
        tick;
        bus.ret = 1'b1;
        bus.rti = also_rti;
        t0 = cyc;
        uq.push_back('{t0 + 1, 16'd5});
        uq.push_back('{t0 + 2, 16'd6});
        uq.push_back('{t0 + 3, 16'd8});
        pq.push_back('{t0 + 4, {hi, lo}, 1'b0, 4'd0});
        tick;
        bus.ret = 1'b0;
        bus.rti = 1'b0;
        tick;
        bus.mem_data = hi;
        tick;
        bus.mem_data = lo;
        tick;
        bus.mem_data = 16'd0;
    endtask

    task automatic run_abort(input int rc);
        int t0;
        logic [15:0] codes [3];
        codes[0] = 16'd5;
        codes[1] = 16'd6;
        codes[2] = 16'd8;
        tick;
        bus.ret = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= rc; k++)
            uq.push_back('{t0 + k, codes[k-1]});
        for (int k = 1; k <= rc; k++) begin
            tick;
            bus.ret = 1'b0;
            bus.mem_data = 16'h7700 + 16'(k);
            if (k == rc) reset = 1'b1;
        end
        tick;
        reset = 1'b0;
        bus.mem_data = 16'd0;
        check("abort_out", {16'd0, bus.out}, 32'd0);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_pc_out", bus.pc_out, 32'd0);
        check("abort_pc_load", {31'd0, bus.pc_load}, 32'd0);
        repeat (4) tick;
    endtask

    initial begin
        bus.ret = 1'b0;
        bus.rti = 1'b0;
        bus.mem_data = 16'd0;
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        mon_en = 1'b1;
        tick;
        check("rst_out", {16'd0, bus.out}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);
        check("rst_pc_load", {31'd0, bus.pc_load}, 32'd0);
        check("rst_flags_load", {31'd0, bus.flags_load}, 32'd0);

        run_abort(2);

        run_ret(16'h0012, 16'h3456, 1'b0);
        check("t4_stall", {31'd0, bus.stall}, 32'd0);
        repeat (3) tick;
        check("pc_hold", bus.pc_out, 32'h00123456);

        // ret held high for the whole sequence: restart only from T4
        begin
            int t0;
            tick;
            bus.ret = 1'b1;
            t0 = cyc;
            uq.push_back('{t0 + 1, 16'd5});
            uq.push_back('{t0 + 2, 16'd6});
            uq.push_back('{t0 + 3, 16'd8});
            pq.push_back('{t0 + 4, 32'h11112222, 1'b0, 4'd0});
            uq.push_back('{t0 + 5, 16'd5});
            uq.push_back('{t0 + 6, 16'd6});
            uq.push_back('{t0 + 7, 16'd8});
            pq.push_back('{t0 + 8, 32'h33334444, 1'b0, 4'd0});
            tick;
            tick;
            bus.mem_data = 16'h1111;
            tick;
            bus.mem_data = 16'h2222;
            tick;
            bus.mem_data = 16'd0;
            tick;
            bus.ret = 1'b0;
            tick;
            bus.mem_data = 16'h3333;
            tick;
            bus.mem_data = 16'h4444;
            tick;
            bus.mem_data = 16'd0;
            repeat (2) tick;
        end

`ifdef RET_FSM_RTI_EN
        begin
            int t0;
            tick;
            bus.rti = 1'b1;
            t0 = cyc;
            uq.push_back('{t0 + 1, 16'd5});
            uq.push_back('{t0 + 2, 16'd6});
            uq.push_back('{t0 + 3, 16'd7});
            uq.push_back('{t0 + 4, 16'd8});
            pq.push_back('{t0 + 5, 32'hABCD0001, 1'b1, 4'hA});
            tick;
            bus.rti = 1'b0;
            tick;
            bus.mem_data = 16'hABCD;
            tick;
            bus.mem_data = 16'h0001;
            tick;
            bus.mem_data = 16'h000A;
            tick;
            bus.mem_data = 16'd0;
            repeat (3) tick;
            check("flags_hold", {28'd0, bus.flags_out}, 32'hA);
        end
`else
        bus.rti = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rti_off_out", {16'd0, bus.out}, 32'd0);
            check("rti_off_stall", {31'd0, bus.stall}, 32'd0);
        end
        bus.rti = 1'b0;
        run_ret(16'hBEEF, 16'hCAFE, 1'b1);
        repeat (2) tick;
        check("rti_off_flags_out", {28'd0, bus.flags_out}, 32'd0);
`endif

        run_abort(3);

        repeat (4) tick;
        check("uop_queue_drained", uq.size(), 32'd0);
        check("load_queue_drained", pq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
